// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers: 32-step shift-add
// multiply, 32-step restoring divide, sign fix-up in a final FIX cycle.
module mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] LAST    = 6'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 is_div_q, is_div_d;
  logic                 wr_q, wr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, div_rem, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic [WIDTH-1:0]     quo, rmd;

  assign sgn_op = (funct == F_MULT) || (funct == F_DIV);
  assign a_neg  = sgn_op & A[WIDTH-1];
  assign b_neg  = sgn_op & B[WIDTH-1];
  assign mag_a  = a_neg ? -A : A;
  assign mag_b  = b_neg ? -B : B;

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

  // Divide: partial remainder in the high half, quotient bits enter at bit 0.
  assign div_rem  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_diff = div_rem - {1'b0, opnd_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_next = {div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0],
                     work_q[WIDTH-2:0], div_ge};

  assign prod = neg_q  ? -work_q : work_q;
  assign quo  = neg_q  ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
  assign rmd  = rneg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    wr_d     = wr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          case (funct)
            F_MULT, F_MULTU: begin
              work_d   = {{WIDTH{1'b0}}, mag_b};
              opnd_d   = mag_a;
              neg_d    = a_neg ^ b_neg;
              rneg_d   = 1'b0;
              is_div_d = 1'b0;
              wr_d     = 1'b1;
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = S_MUL;
            end
            F_DIV, F_DIVU: begin
              is_div_d = 1'b1;
              busy_d   = 1'b1;
              cnt_d    = '0;
              if (B == '0) begin
                // Divide by zero: one busy cycle through FIX with the write disabled.
                wr_d    = 1'b0;
                state_d = S_FIX;
              end else begin
                work_d  = {{WIDTH{1'b0}}, mag_a};
                opnd_d  = mag_b;
                neg_d   = a_neg ^ b_neg;
                rneg_d  = a_neg;
                wr_d    = 1'b1;
                state_d = S_DIV;
              end
            end
            F_MTHI:  hi_d = A;
            F_MTLO:  lo_d = A;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        work_d = mul_next;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_DIV: begin
        work_d = div_next;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (wr_q) begin
          if (is_div_q) begin
            hi_d = rmd;
            lo_d = quo;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flush aborts anything in flight, including the FIX write.
    if (cancel && state_q != S_IDLE) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: fixed-latency mult/div results, divide by zero,
// cancel, mthi/mtlo, ignored starts and asynchronous reset.
module tb_mdu_ctrl;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        CLK = 1'b0;
  logic        RESET_N, start, cancel;
  logic [5:0]  funct;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .funct(funct), .A(A), .B(B),
    .cancel(cancel), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op, scrambles operands after acceptance, checks the fixed
  // 33-cycle latency and results. Returns in the done cycle.
  task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    start = 1'b1; funct = f; A = a; B = b;
    tick();
    start = 1'b0; A = ~a; B = ~b;
    chk({tag, "_busyE"}, busy, 1'b1);
    chk({tag, "_doneE"}, done, 1'b0);
    repeat (32) tick();
    chk({tag, "_busy32"}, busy, 1'b1);
    chk({tag, "_done32"}, done, 1'b0);
    tick();
    chk({tag, "_busy33"}, busy, 1'b0);
    chk({tag, "_done33"}, done, 1'b1);
    chk({tag, "_hi"}, HI, ehi);
    chk({tag, "_lo"}, LO, elo);
  endtask

  initial begin
    RESET_N = 1'b0; start = 1'b0; cancel = 1'b0; funct = '0; A = '0; B = '0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    RESET_N = 1'b1;

    // First edge after release accepts; each following op starts in the done cycle.
    do_op("mult",  F_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
    do_op("multu", F_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA);
    do_op("div",   F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("divu",  F_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);
    do_op("div_pn", F_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    do_op("div_min", F_DIV, 32'h80000000, 32'h00000001, 32'h00000000, 32'h80000000);
    do_op("mult_big", F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    tick();
    chk("done_one_cycle", done, 1'b0);

    // mthi then divide by zero.
    start = 1'b1; funct = F_MTHI; A = 32'h0000AAAA;
    tick();
    start = 1'b0;
    chk("mthi_hi", HI, 32'h0000AAAA);
    chk("mthi_busy", busy, 1'b0);
    chk("mthi_done", done, 1'b0);
    start = 1'b1; funct = F_DIVU; A = 32'h7; B = 32'h0;
    tick();
    start = 1'b0;
    chk("dz_busyE", busy, 1'b1);
    chk("dz_doneE", done, 1'b0);
    tick();
    chk("dz_busy1", busy, 1'b0);
    chk("dz_done1", done, 1'b1);
    chk("dz_hi", HI, 32'h0000AAAA);
    chk("dz_lo", LO, 32'h0);
    tick();
    chk("dz_done2", done, 1'b0);

    // Starts issued while a multu is busy must be ignored.
    start = 1'b1; funct = F_MULTU; A = 32'd5; B = 32'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; funct = F_DIVU; A = 32'd100; B = 32'd7;
    tick();
    funct = F_MTLO; A = 32'hDEADBEEF;
    tick();
    start = 1'b0;
    chk("ign_lo_mid", LO, 32'h0);
    repeat (26) tick();
    chk("ign_busy32", busy, 1'b1);
    tick();
    chk("ign_done33", done, 1'b1);
    chk("ign_hi", HI, 32'h0);
    chk("ign_lo", LO, 32'd35);
    tick();

    // Cancel a divu in flight, sampled at E+11.
    start = 1'b1; funct = F_DIVU; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0;
    repeat (10) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cxl_busy", busy, 1'b0);
    chk("cxl_done", done, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("cxl_no_done", {busy, done}, 2'b00);
    end
    chk("cxl_hi", HI, 32'h0);
    chk("cxl_lo", LO, 32'd35);
    start = 1'b1; funct = F_MTHI; A = 32'h12345678;
    tick();
    start = 1'b0;
    chk("mthi2_hi", HI, 32'h12345678);
    chk("mthi2_done", done, 1'b0);

    // Cancel beats a same-cycle start in IDLE.
    start = 1'b1; cancel = 1'b1; funct = F_MTLO; A = 32'hCAFEF00D;
    tick();
    start = 1'b1; funct = F_MULT; A = 32'd3; B = 32'd3;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("cs_lo", LO, 32'd35);
    chk("cs_busy", busy, 1'b0);

    // Cancel in the FIX cycle suppresses write and done.
    start = 1'b1; funct = F_MULTU; A = 32'd9; B = 32'd9;
    tick();
    start = 1'b0;
    repeat (32) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cfix_busy", busy, 1'b0);
    chk("cfix_done", done, 1'b0);
    chk("cfix_hi", HI, 32'h12345678);
    chk("cfix_lo", LO, 32'd35);

    // Asynchronous reset mid-mult.
    start = 1'b1; funct = F_MULTU; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    tick();
    start = 1'b0;
    repeat (15) tick();
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_hi", HI, 32'h0);
    chk("arst_lo", LO, 32'h0);
    tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("arst_quiet", {busy, done}, 2'b00);
    end
    do_op("post_rst", F_MULTU, 32'd6, 32'd7, 32'h0, 32'd42);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/HI/LO width; only 32 is required to work.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request, sampled on the rising edge.
REQ-005 funct  input  6  operation: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo.
REQ-006 A  input  32  rs operand (dividend / multiplicand / mthi-mtlo source).
REQ-007 B  input  32  rt operand (divisor / multiplier).
REQ-008 cancel  input  1  pipeline flush; aborts an in-flight operation.
REQ-009 busy  output  1  operation in flight; the pipeline stalls mfhi/mflo/mult/div while it is high.
REQ-010 done  output  1  one-cycle pulse; HI/LO were updated on the preceding edge.
REQ-011 HI  output  32  HI register.
REQ-012 LO  output  32  LO register.

Function
REQ-013 The block SHALL have 4 states (IDLE, MUL, DIV, FIX), a 6-bit iteration counter, and a 64-bit working register plus a 32-bit divisor/multiplicand register.
REQ-014 In IDLE, start=1 with funct=mult/multu at edge E SHALL capture operand magnitudes and operand signs (signs only for mult), set busy=1 and enter MUL.
REQ-015 In IDLE, start=1 with funct=div/divu and B!=0 at edge E SHALL capture operands the same way and enter DIV.
REQ-016 MUL SHALL perform one shift-add step per cycle for 32 cycles (edges E+1..E+32), then enter FIX.
REQ-017 DIV SHALL perform one restoring shift-subtract step per cycle for 32 cycles (edges E+1..E+32), then enter FIX.
REQ-018 At edge E+33, FIX SHALL write HI/LO, return to IDLE, clear busy and set done=1 for exactly one cycle; latency is fixed for signed and unsigned.
REQ-019 mult: {HI,LO} SHALL equal the 64-bit two's-complement product, negated when the operand signs differ; multu: the unsigned product.
REQ-020 div: LO SHALL be the quotient truncated toward zero and HI the remainder carrying the dividend's sign; divu: unsigned quotient/remainder.
REQ-021 div/divu with B==0 SHALL leave HI/LO unchanged, hold busy=1 for one cycle, return to IDLE at E+1 and pulse done after E+1.
REQ-022 mthi/mtlo with start=1 in IDLE SHALL write A into HI/LO at edge E, with no busy and no done.
REQ-023 start while busy=1 SHALL be ignored for all funct values; start with any other funct SHALL be ignored.
REQ-024 cancel=1 while busy SHALL return the block to IDLE at the next edge with busy=0, no done, and HI/LO unchanged.
REQ-025 cancel=1 and start=1 in the same IDLE cycle: cancel SHALL win and nothing is accepted, including mthi/mtlo.
REQ-026 cancel in the FIX cycle SHALL suppress the HI/LO write and done.
REQ-027 A/B changes after the accepting edge SHALL NOT affect the result.
REQ-028 Back-to-back: start may be accepted in the cycle done=1 (block is IDLE).

Reset
REQ-029 RESET_N=0 SHALL immediately force IDLE, counter=0, busy=0, done=0, HI=0, LO=0 and working registers to 0, including mid-operation.
REQ-030 The first edge after RESET_N rises SHALL be able to accept start.

Verification
REQ-031 mult A=FFFFFFFE, B=00000003 at edge E -> busy from E, done after E+33, HI=FFFFFFFF, LO=FFFFFFFA.
REQ-032 multu A=FFFFFFFE, B=00000003 -> HI=00000002, LO=FFFFFFFA, same latency.
REQ-033 div A=FFFFFFF9, B=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; divu A=00000064, B=00000007 -> LO=0000000E, HI=00000002.
REQ-034 divu A=7, B=0 with HI=0000AAAA -> done after E+1, HI still 0000AAAA; start during busy of a mult -> ignored, mult result intact.
REQ-035 divu 100/7 with cancel at E+10 -> busy=0 after E+11, no done, HI/LO hold prior values; then mthi A=12345678 -> HI=12345678 next edge, done stays 0.
REQ-036 RESET_N low at E+15 of a mult -> HI=LO=0, busy=0, done=0 asynchronously; no done appears after release.
